// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: DEPTH-entry circular instruction buffer between fetch and decode,
// with a registered decode-stage output (id_*), flush, and zero-instruction bubbles.
// Optional build macro IF_ID_BYPASS_EN: an empty-queue push with decode advancing
// goes straight into id_* (1-cycle latency) instead of passing through the buffer.
module if_id_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  output logic                       if_ready,
  input  logic [5:0]                 stall,
  input  logic                       flush,
  output logic                       id_valid,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = ADDR_W + INST_W;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     fill;
  logic [EW-1:0]     mem_q [DEPTH];
  logic              id_valid_q, id_valid_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              empty, full, push, store, adv;
  logic              unused_stall;

  // Occupancy, handshake and advance decode from registered pointers
  always_comb begin
    fill         = wr_ptr_q - rd_ptr_q;
    empty        = (fill == '0);
    full         = (fill == PW'(DEPTH));
    if_ready     = !full && !flush;
    push         = if_valid && if_ready;
    adv          = !stall[2];
    q_count      = CW'(fill);
    unused_stall = ^{stall[5:3], stall[1:0]};
  end

  // Next-state for pointers and the decode-stage output register
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    store      = push;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      id_valid_d = 1'b0;
      id_pc_d    = '0;
      id_inst_d  = '0;
      store      = 1'b0;
    end else if (adv) begin
      if (!empty) begin
        {id_pc_d, id_inst_d} = mem_q[rd_ptr_q[AW-1:0]];
        id_valid_d           = 1'b1;
        rd_ptr_d             = rd_ptr_q + PW'(1);
      end
`ifdef IF_ID_BYPASS_EN
      else if (push) begin
        // Empty queue: word goes directly to decode and is never stored
        id_pc_d    = if_pc;
        id_inst_d  = if_inst;
        id_valid_d = 1'b1;
        store      = 1'b0;
      end
`endif
      else begin
        id_valid_d = 1'b0;
        id_pc_d    = '0;
        id_inst_d  = '0;
      end
    end
    if (store) wr_ptr_d = wr_ptr_q + PW'(1);
  end

  // Pointer and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

  // Storage array write; contents need no reset
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q[AW-1:0]] <= {if_pc, if_inst};
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Testbench for if_id_fetch_queue: directed stimulus, scoreboard of accepted words
// checked in order by a monitor, plus directed checks of count, ready and latency.
module tb_if_id_fetch_queue;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
`ifdef IF_ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_valid = 1'b0;
  logic [ADDR_W-1:0] if_pc = '0;
  logic [INST_W-1:0] if_inst = '0;
  logic              if_ready;
  logic [5:0]        stall = '0;
  logic              flush = 1'b0;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [2:0]        q_count;

  if_id_fetch_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  logic [63:0] sb [$];
  logic        presented = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Record accepted pushes; flush or reset discards everything not yet presented
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      presented = 1'b0;
    end else begin
      presented = !stall[2] && !flush;
      if (flush) sb.delete();
      else if (if_valid && if_ready) sb.push_back({if_pc, if_inst});
    end
  end

  // After each advancing edge: a valid word must be the oldest expected one, else a zero bubble
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (!rst && presented) begin
      if (id_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL sb_unexpected: got pc 0x%0h, expected no valid word", id_pc);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", id_pc, e[63:32]);
          chk("sb_inst", id_inst, e[31:0]);
        end
      end else begin
        chk("bubble_pc", id_pc, 32'h0);
        chk("bubble_inst", id_inst, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_inst  = {16'hA5A5, pc[15:0]};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pcs [3];
    logic [31:0] exp_pc;
    logic [31:0] exp_q;
    logic [31:0] t3_pc [3];
    logic [31:0] t3_q  [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    t3_pc[0] = 32'h108; t3_pc[1] = 32'h10C; t3_pc[2] = 32'h110;
    t3_q[0] = 2; t3_q[1] = 1; t3_q[2] = 0;

    // Reset state
    #1 rst = 1'b1;
    step(); step();
    chk("rst_valid", id_valid, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_inst", id_inst, 0);
    chk("rst_q", q_count, 0);
    chk("rst_ready", if_ready, 1);
    rst = 1'b0;
    step();

    // Streaming, decode never stalled
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, pcs[i]); else drive(1'b0, 32'h0);
      step();
      if (BYP) begin
        exp_pc = (i < 3) ? pcs[i] : 32'h0;
        exp_q  = 0;
      end else begin
        exp_pc = 32'h0;
        if (i >= 1 && i <= 3) exp_pc = pcs[i-1];
        exp_q  = (i <= 2) ? 1 : 0;
      end
      chk("t2_pc", id_pc, exp_pc);
      chk("t2_valid", id_valid, (exp_pc != 0) ? 1 : 0);
      chk("t2_q", q_count, exp_q);
    end

    // Underflow: three bubbles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_valid", id_valid, 0);
      chk("t5_pc", id_pc, 0);
      chk("t5_q", q_count, 0);
    end

    // Fill while decode is stalled, then drain in order
    stall = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i));
      chk("t3_ready", if_ready, 1);
      step();
      chk("t3_q", q_count, 32'(i + 1));
    end
    drive(1'b1, 32'h110);
    chk("t3_full_ready", if_ready, 0);
    step();
    chk("t3_full_q", q_count, 4);
    chk("t3_held_valid", id_valid, 0);
    stall = '0;
    step();
    chk("t3_pop0_pc", id_pc, 32'h100);
    chk("t3_pop0_q", q_count, 3);
    chk("t3_ready_again", if_ready, 1);
    step();
    chk("t3_pop1_pc", id_pc, 32'h104);
    chk("t3_pop1_q", q_count, 3);
    drive(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_drain_pc", id_pc, t3_pc[i]);
      chk("t3_drain_q", q_count, t3_q[i]);
    end
    step();
    chk("t3_end_valid", id_valid, 0);
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // Flush with three queued and one presented
    stall = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i));
      step();
    end
    drive(1'b0, 32'h0);
    stall = '0;
    step();
    chk("t4_pre_pc", id_pc, 32'h200);
    chk("t4_pre_valid", id_valid, 1);
    chk("t4_pre_q", q_count, 3);
    flush = 1'b1;
    drive(1'b1, 32'h300);
    #1 chk("t4_flush_ready", if_ready, 0);
    step();
    chk("t4_valid", id_valid, 0);
    chk("t4_inst", id_inst, 0);
    chk("t4_pc", id_pc, 0);
    chk("t4_q", q_count, 0);
    flush = 1'b0;
    drive(1'b0, 32'h0);
    step();
    chk("t4_post_valid", id_valid, 0);
    chk("t4_post_q", q_count, 0);

    // Flush while decode is stalled still empties the queue
    stall = 6'b000100;
    drive(1'b1, 32'h400); step();
    drive(1'b1, 32'h404); step();
    chk("t4s_q", q_count, 2);
    flush = 1'b1;
    drive(1'b0, 32'h0);
    step();
    chk("t4s_flush_q", q_count, 0);
    chk("t4s_flush_valid", id_valid, 0);
    flush = 1'b0;
    stall = '0;
    step();
    chk("t4s_post_valid", id_valid, 0);

    // Asynchronous reset mid-stream
    stall = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i));
      step();
    end
    drive(1'b0, 32'h0);
    stall = '0;
    step();
    chk("t1_pre_q", q_count, 3);
    chk("t1_pre_valid", id_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_valid", id_valid, 0);
    chk("t1_pc", id_pc, 0);
    chk("t1_q", q_count, 0);
    step();
    rst = 1'b0;
    step();
    chk("t1_after_valid", id_valid, 0);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
